// File: rtl/spike_motor_decoder.sv
// spike_motor_decoder: counts left/right output spikes over a fixed window,
// converts the rate difference into a differential motor command, offers it
// on a valid/ready port and drives two PWM outputs from the accepted duties.
module spike_motor_decoder #(
  parameter int WIN_CYCLES = 1024,
  parameter int CNT_W      = 8,
  parameter int PWM_W      = 8,
  parameter int BASE_DUTY  = 128,
  parameter int GAIN_SHIFT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       spike_in,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic [PWM_W-1:0] cmd_duty_l,
  output logic [PWM_W-1:0] cmd_duty_r,
  output logic [1:0]       cmd_dir,
  output logic             pwm_l,
  output logic             pwm_r,
  output logic             overrun
);

  localparam int WIN_W = (WIN_CYCLES > 2) ? $clog2(WIN_CYCLES) : 1;
  localparam int AW    = CNT_W + GAIN_SHIFT + 3;

  localparam logic [WIN_W-1:0]     WIN_LAST  = WIN_W'(WIN_CYCLES - 1);
  localparam logic signed [AW-1:0] BASE_S    = AW'(BASE_DUTY);
  localparam logic signed [AW-1:0] DUTY_MAX  = AW'((1 << PWM_W) - 1);

  localparam logic [1:0] ST_ACCUM   = 2'd0;
  localparam logic [1:0] ST_COMPUTE = 2'd1;
  localparam logic [1:0] ST_OFFER   = 2'd2;

  // Saturating increment: a full counter stays at its maximum.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                               input logic inc);
    if (inc && (c != '1)) return c + CNT_W'(1);
    return c;
  endfunction

  // Clamp a signed duty request into the unsigned PWM range.
  function automatic logic [PWM_W-1:0] clamp_duty(input logic signed [AW-1:0] v);
    if (v[AW-1]) return '0;
    if (v > DUTY_MAX) return '1;
    return v[PWM_W-1:0];
  endfunction

  logic [WIN_W-1:0]     win_cnt;
  logic [CNT_W-1:0]     cnt_l, cnt_r;
  logic [CNT_W-1:0]     cnt_l_nx, cnt_r_nx;
  logic [CNT_W-1:0]     snap_l_p0, snap_r_p0;
  logic [1:0]           state;
  logic                 win_end;
  logic                 accept;
  logic signed [AW-1:0] diff, off, sum_l, sum_r;
  logic [PWM_W-1:0]     duty_l_act, duty_r_act;
  logic [PWM_W-1:0]     pwm_cnt;

  // Window end, next-count values and the steering arithmetic on the snapshot.
  always_comb begin
    win_end  = en && (win_cnt == WIN_LAST);
    accept   = cmd_valid && cmd_ready;
    cnt_l_nx = sat_inc(cnt_l, en && spike_in[0]);
    cnt_r_nx = sat_inc(cnt_r, en && spike_in[1]);
    diff     = $signed(AW'(snap_l_p0)) - $signed(AW'(snap_r_p0));
    off      = diff <<< GAIN_SHIFT;
    sum_l    = BASE_S - off;
    sum_r    = BASE_S + off;
  end

  // Window position and spike counters; both freeze while en is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_cnt <= '0;
      cnt_l   <= '0;
      cnt_r   <= '0;
    end else if (en) begin
      win_cnt <= win_end ? '0 : win_cnt + WIN_W'(1);
      cnt_l   <= win_end ? '0 : cnt_l_nx;
      cnt_r   <= win_end ? '0 : cnt_r_nx;
    end
  end

  // Command FSM: snapshot at window end, register payload, hold until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_ACCUM;
      snap_l_p0  <= '0;
      snap_r_p0  <= '0;
      cmd_valid  <= 1'b0;
      cmd_duty_l <= '0;
      cmd_duty_r <= '0;
      cmd_dir    <= 2'b00;
      overrun    <= 1'b0;
    end else begin
      case (state)
        // Stage p0: capture the finished window, including this cycle's spikes.
        ST_ACCUM: begin
          if (win_end) begin
            snap_l_p0 <= cnt_l_nx;
            snap_r_p0 <= cnt_r_nx;
            state     <= ST_COMPUTE;
          end
        end
        // Stage p1: payload and valid are registered together.
        ST_COMPUTE: begin
          cmd_valid  <= 1'b1;
          cmd_duty_l <= clamp_duty(sum_l);
          cmd_duty_r <= clamp_duty(sum_r);
          cmd_dir    <= {snap_l_p0 > snap_r_p0, snap_r_p0 > snap_l_p0};
          state      <= ST_OFFER;
          if (win_end) overrun <= 1'b1;
        end
        ST_OFFER: begin
          if (win_end) overrun <= 1'b1;
          if (accept) begin
            cmd_valid <= 1'b0;
            state     <= ST_ACCUM;
          end
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

  // Free-running PWM with duties latched on the accepting handshake edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_cnt    <= '0;
      duty_l_act <= '0;
      duty_r_act <= '0;
      pwm_l      <= 1'b0;
      pwm_r      <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      pwm_l   <= (pwm_cnt < duty_l_act);
      pwm_r   <= (pwm_cnt < duty_r_act);
      if (accept) begin
        duty_l_act <= cmd_duty_l;
        duty_r_act <= cmd_duty_r;
      end
    end
  end

endmodule

// File: tb/tb_spike_motor_decoder.sv
// Testbench for spike_motor_decoder: a short-window instance (16 cycles) for
// timing/handshake scenarios and a long-window instance (512 cycles) for
// clamping and counter saturation, both fed from the same stimulus.
module tb_spike_motor_decoder;

  localparam int SW = 16;
  localparam int BW = 512;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       cmd_ready;
  logic [1:0] spike;

  logic       s_valid, s_pl, s_pr, s_ovr;
  logic [7:0] s_dl, s_dr;
  logic [1:0] s_dir;
  logic       b_valid, b_pl, b_pr, b_ovr;
  logic [7:0] b_dl, b_dr;
  logic [1:0] b_dir;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  spike_motor_decoder #(.WIN_CYCLES(SW), .CNT_W(8), .PWM_W(8), .BASE_DUTY(128), .GAIN_SHIFT(2)) u_small (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike), .cmd_valid(s_valid), .cmd_ready(cmd_ready),
    .cmd_duty_l(s_dl), .cmd_duty_r(s_dr), .cmd_dir(s_dir), .pwm_l(s_pl), .pwm_r(s_pr), .overrun(s_ovr));

  spike_motor_decoder #(.WIN_CYCLES(BW), .CNT_W(8), .PWM_W(8), .BASE_DUTY(128), .GAIN_SHIFT(2)) u_big (
    .clk(clk), .rst(rst), .en(en), .spike_in(spike), .cmd_valid(b_valid), .cmd_ready(cmd_ready),
    .cmd_duty_l(b_dl), .cmd_duty_r(b_dr), .cmd_dir(b_dir), .pwm_l(b_pl), .pwm_r(b_pr), .overrun(b_ovr));

  // Reference: saturate counts, scale the difference, clamp both duties.
  function automatic void model(input int cl, input int cr, output int dl, output int dr, output int dir);
    int sl, sr, off;
    sl  = (cl > 255) ? 255 : cl;
    sr  = (cr > 255) ? 255 : cr;
    off = (sl - sr) * 4;
    dl  = 128 - off;
    dr  = 128 + off;
    if (dl < 0) dl = 0;
    if (dl > 255) dl = 255;
    if (dr < 0) dr = 0;
    if (dr > 255) dr = 255;
    dir = ((sl > sr) ? 2 : 0) + ((sr > sl) ? 1 : 0);
  endfunction

  // Drive one window of n enabled cycles, then freeze en and capture the
  // command port one and two edges after the window-end edge.
  // mode: 0 random, 1 10L/2R, 2 both every cycle, 3 0L/60R,
  //       4 5-cycle en gap with spikes + L on last cycle, 5 random en.
  task automatic run_window(input int n, input int mode, input bit big,
                            output int cl, output int cr, output logic v0, output logic v1,
                            output logic [7:0] dl, output logic [7:0] dr, output logic [1:0] dir,
                            output logic ov);
    int k = 0;
    int gap = 0;
    cl = 0;
    cr = 0;
    while (k < n) begin
      @(negedge clk);
      en    = 1'b1;
      spike = 2'($urandom_range(0, 3));
      case (mode)
        1: spike = {k >= 14, k < 10};
        2: spike = 2'b11;
        3: spike = {k < 60, 1'b0};
        4: begin
          if (k == 7 && gap < 5) begin
            en = 1'b0;
            spike = 2'b11;
            gap++;
          end else if (k == n - 1) begin
            spike[0] = 1'b1;
          end
        end
        5: en = ($urandom_range(0, 3) != 0);
        default: ;
      endcase
      if (en) begin
        k++;
        cl += int'(spike[0]);
        cr += int'(spike[1]);
      end
    end
    @(negedge clk);
    en    = 1'b0;
    spike = 2'b00;
    v0    = big ? b_valid : s_valid;
    @(negedge clk);
    v1    = big ? b_valid : s_valid;
    dl    = big ? b_dl : s_dl;
    dr    = big ? b_dr : s_dr;
    dir   = big ? b_dir : s_dir;
    ov    = big ? b_ovr : s_ovr;
  endtask

  task automatic measure_pwm(input bit big, output int hl, output int hr);
    hl = 0;
    hr = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      hl += int'(big ? b_pl : s_pl);
      hr += int'(big ? b_pr : s_pr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; spike = 2'b00; cmd_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({s_valid, s_dl, s_dr, s_dir, s_pl, s_pr, s_ovr} !== 21'd0) begin
      n_fail++; $display("FAIL reset_small: got %h expected 0", {s_valid, s_dl, s_dr, s_dir, s_pl, s_pr, s_ovr});
    end
    n_chk++;
    if ({b_valid, b_dl, b_dr, b_dir, b_pl, b_pr, b_ovr} !== 21'd0) begin
      n_fail++; $display("FAIL reset_big: got %h expected 0", {b_valid, b_dl, b_dr, b_dir, b_pl, b_pr, b_ovr});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int cl, cr, edl, edr, edir, hl, hr;
    logic v0, v1, ov;
    logic [7:0] dl, dr;
    logic [1:0] dir;
    cmd_ready = 1'b1;
    run_window(SW, 1, 1'b0, cl, cr, v0, v1, dl, dr, dir, ov);
    model(cl, cr, edl, edr, edir);
    n_chk++; if (v0 !== 1'b0) begin n_fail++; $display("FAIL basic_valid_e1: got %b expected 0", v0); end
    n_chk++; if (v1 !== 1'b1) begin n_fail++; $display("FAIL basic_valid_e2: got %b expected 1", v1); end
    n_chk++; if (dl !== 8'(edl)) begin n_fail++; $display("FAIL basic_duty_l: got %0d expected %0d", dl, edl); end
    n_chk++; if (dr !== 8'(edr)) begin n_fail++; $display("FAIL basic_duty_r: got %0d expected %0d", dr, edr); end
    n_chk++; if (dir !== 2'(edir)) begin n_fail++; $display("FAIL basic_dir: got %b expected %0d", dir, edir); end
    @(negedge clk);
    n_chk++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL basic_one_cycle: got %b expected 0", s_valid); end
    n_chk++; if (s_dl !== 8'(edl)) begin n_fail++; $display("FAIL basic_retain: got %0d expected %0d", s_dl, edl); end
    @(negedge clk);
    measure_pwm(1'b0, hl, hr);
    n_chk++; if (hl != edl) begin n_fail++; $display("FAIL basic_pwm_l: got %0d expected %0d", hl, edl); end
    n_chk++; if (hr != edr) begin n_fail++; $display("FAIL basic_pwm_r: got %0d expected %0d", hr, edr); end
  endtask

  task automatic test_random();
    int cl, cr, edl, edr, edir;
    logic v0, v1, ov;
    logic [7:0] dl, dr;
    logic [1:0] dir;
    cmd_ready = 1'b1;
    for (int w = 0; w < 6; w++) begin
      run_window(SW, (w < 3) ? 0 : 5, 1'b0, cl, cr, v0, v1, dl, dr, dir, ov);
      model(cl, cr, edl, edr, edir);
      n_chk++; if ({v0, v1} !== 2'b01) begin n_fail++; $display("FAIL rand_valid w%0d: got %b expected 01", w, {v0, v1}); end
      n_chk++; if (dl !== 8'(edl)) begin n_fail++; $display("FAIL rand_duty_l w%0d: got %0d expected %0d", w, dl, edl); end
      n_chk++; if (dr !== 8'(edr)) begin n_fail++; $display("FAIL rand_duty_r w%0d: got %0d expected %0d", w, dr, edr); end
      n_chk++; if (dir !== 2'(edir)) begin n_fail++; $display("FAIL rand_dir w%0d: got %b expected %0d", w, dir, edir); end
      @(negedge clk);
    end
  endtask

  task automatic test_en_gap();
    int cl, cr, edl, edr, edir;
    logic v0, v1, ov;
    logic [7:0] dl, dr;
    logic [1:0] dir;
    cmd_ready = 1'b1;
    run_window(SW, 4, 1'b0, cl, cr, v0, v1, dl, dr, dir, ov);
    model(cl, cr, edl, edr, edir);
    n_chk++; if ({v0, v1} !== 2'b01) begin n_fail++; $display("FAIL gap_valid: got %b expected 01", {v0, v1}); end
    n_chk++; if (dl !== 8'(edl)) begin n_fail++; $display("FAIL gap_duty_l: got %0d expected %0d", dl, edl); end
    n_chk++; if (dr !== 8'(edr)) begin n_fail++; $display("FAIL gap_duty_r: got %0d expected %0d", dr, edr); end
    @(negedge clk);
  endtask

  task automatic test_overrun();
    int cl, cr, edl, edr, edir, xl, xr, xdir;
    logic v0, v1, ov;
    logic [7:0] dl, dr;
    logic [1:0] dir;
    cmd_ready = 1'b0;
    run_window(SW, 1, 1'b0, cl, cr, v0, v1, dl, dr, dir, ov);
    model(cl, cr, edl, edr, edir);
    n_chk++; if (v1 !== 1'b1) begin n_fail++; $display("FAIL ovr_first_valid: got %b expected 1", v1); end
    n_chk++; if (ov !== 1'b0) begin n_fail++; $display("FAIL ovr_early: got %b expected 0", ov); end
    run_window(SW, 2, 1'b0, cl, cr, v0, v1, dl, dr, dir, ov);
    n_chk++; if ({v0, v1} !== 2'b11) begin n_fail++; $display("FAIL ovr_valid_held: got %b expected 11", {v0, v1}); end
    n_chk++; if (dl !== 8'(edl)) begin n_fail++; $display("FAIL ovr_payload_l: got %0d expected %0d", dl, edl); end
    n_chk++; if (dir !== 2'(edir)) begin n_fail++; $display("FAIL ovr_payload_dir: got %b expected %0d", dir, edir); end
    n_chk++; if (ov !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", ov); end
    cmd_ready = 1'b1;
    @(negedge clk);
    n_chk++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_accept: got %b expected 0", s_valid); end
    n_chk++; if (s_ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 1", s_ovr); end
    run_window(SW, 0, 1'b0, cl, cr, v0, v1, dl, dr, dir, ov);
    model(cl, cr, xl, xr, xdir);
    n_chk++; if ({v0, v1} !== 2'b01) begin n_fail++; $display("FAIL ovr_next_valid: got %b expected 01", {v0, v1}); end
    n_chk++; if (dr !== 8'(xr)) begin n_fail++; $display("FAIL ovr_next_duty_r: got %0d expected %0d", dr, xr); end
    n_chk++; if (ov !== 1'b1) begin n_fail++; $display("FAIL ovr_still: got %b expected 1", ov); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cl, cr, edl, edr, edir;
    logic v0, v1, ov;
    logic [7:0] dl, dr;
    logic [1:0] dir;
    cmd_ready = 1'b0;
    run_window(SW, 0, 1'b0, cl, cr, v0, v1, dl, dr, dir, ov);
    n_chk++; if (s_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_offer: got %b expected 1", s_valid); end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({s_valid, s_dl, s_dr, s_dir, s_pl, s_pr, s_ovr} !== 21'd0) begin
      n_fail++; $display("FAIL rmid_offer_clear: got %h expected 0", {s_valid, s_dl, s_dr, s_dir, s_pl, s_pr, s_ovr});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      en = 1'b1;
      spike = 2'b11;
    end
    @(negedge clk);
    en = 1'b0;
    spike = 2'b00;
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({s_valid, s_ovr, s_pl, s_pr} !== 4'd0) begin
      n_fail++; $display("FAIL rmid_window_clear: got %b expected 0000", {s_valid, s_ovr, s_pl, s_pr});
    end
    @(negedge clk);
    rst = 1'b0;
    cmd_ready = 1'b1;
    run_window(SW, 1, 1'b0, cl, cr, v0, v1, dl, dr, dir, ov);
    model(cl, cr, edl, edr, edir);
    n_chk++; if ({v0, v1} !== 2'b01) begin n_fail++; $display("FAIL rmid_valid: got %b expected 01", {v0, v1}); end
    n_chk++; if (dl !== 8'(edl)) begin n_fail++; $display("FAIL rmid_duty_l: got %0d expected %0d", dl, edl); end
    n_chk++; if (dr !== 8'(edr)) begin n_fail++; $display("FAIL rmid_duty_r: got %0d expected %0d", dr, edr); end
    @(negedge clk);
  endtask

  task automatic test_big();
    int cl, cr, edl, edr, edir, hl, hr;
    logic v0, v1, ov;
    logic [7:0] dl, dr;
    logic [1:0] dir;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cmd_ready = 1'b1;
    run_window(BW, 3, 1'b1, cl, cr, v0, v1, dl, dr, dir, ov);
    model(cl, cr, edl, edr, edir);
    n_chk++; if ({v0, v1} !== 2'b01) begin n_fail++; $display("FAIL clamp_valid: got %b expected 01", {v0, v1}); end
    n_chk++; if (dl !== 8'(edl)) begin n_fail++; $display("FAIL clamp_duty_l: got %0d expected %0d", dl, edl); end
    n_chk++; if (dr !== 8'(edr)) begin n_fail++; $display("FAIL clamp_duty_r: got %0d expected %0d", dr, edr); end
    n_chk++; if (dir !== 2'(edir)) begin n_fail++; $display("FAIL clamp_dir: got %b expected %0d", dir, edir); end
    @(negedge clk);
    n_chk++; if (b_valid !== 1'b0) begin n_fail++; $display("FAIL clamp_accept: got %b expected 0", b_valid); end
    @(negedge clk);
    measure_pwm(1'b1, hl, hr);
    n_chk++; if (hl != edl) begin n_fail++; $display("FAIL clamp_pwm_l: got %0d expected %0d", hl, edl); end
    n_chk++; if (hr != edr) begin n_fail++; $display("FAIL clamp_pwm_r: got %0d expected %0d", hr, edr); end
    run_window(BW, 2, 1'b1, cl, cr, v0, v1, dl, dr, dir, ov);
    model(cl, cr, edl, edr, edir);
    n_chk++; if ({v0, v1} !== 2'b01) begin n_fail++; $display("FAIL sat_valid: got %b expected 01", {v0, v1}); end
    n_chk++; if ({dl, dr} !== {8'(edl), 8'(edr)}) begin n_fail++; $display("FAIL sat_duties: got %0d/%0d expected %0d/%0d", dl, dr, edl, edr); end
    n_chk++; if (dir !== 2'(edir)) begin n_fail++; $display("FAIL sat_dir: got %b expected %0d", dir, edir); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_random();
    test_en_gap();
    test_overrun();
    test_reset_mid();
    test_big();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
